adc_stream_conditioner: RTL and testbench

- Parametrised successor to the per-board ADC sample formatting stage. Sits after the LVDS/IDDR capture and before the sorting logic, in the ADC sample clock domain.
- Takes NUM_CH parallel raw ADC words and converts them from offset-binary or two's complement to signed. Subtracts a per-channel DC offset with saturation.
- Optionally box-car averages and decimates by 2^N, then presents frames on a valid/ready interface with overrun accounting.

---
 rtl/adc_stream_conditioner.sv | 151 +++++++++++++++
 tb/tb_adc_stream_conditioner.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_stream_conditioner.sv
// rtl/adc_stream_conditioner.sv - ADC sample format conversion, DC offset removal, averaging and output stage
//
// Purpose: converts NUM_CH parallel raw ADC words to signed, subtracts a per-channel
// DC offset with saturation, box-car averages and decimates by 2^N, and presents the
// resulting frames on a valid/ready interface, counting frames dropped on backpressure.
//
// Ports:
//   clk            sample clock
//   rst            synchronous active-high reset
//   in_valid       raw frame valid (no backpressure)
//   in_data        raw samples, channel k at [k*DATA_W +: DATA_W]
//   cfg_offset_bin 1 = offset binary input, 0 = two's complement input
//   cfg_avg_log2   averaging exponent N, clamped to AVG_LOG2_MAX
//   cfg_ch_en      per-channel enable
//   cfg_dc_off     signed DC offset per channel
//   out_valid      output frame valid
//   out_ready      downstream accept
//   out_data       signed conditioned samples
//   out_sat        per-channel saturation seen in the block behind this frame
//   overrun_cnt    dropped frame count, saturating
module adc_stream_conditioner #(
   parameter int NUM_CH       = 4,
   parameter int DATA_W       = 12,
   parameter int AVG_LOG2_MAX = 4,
   parameter int CNT_W        = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   input  logic [NUM_CH*DATA_W-1:0] in_data,
   input  logic                     cfg_offset_bin,
   input  logic [3:0]               cfg_avg_log2,
   input  logic [NUM_CH-1:0]        cfg_ch_en,
   input  logic [NUM_CH*DATA_W-1:0] cfg_dc_off,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [NUM_CH*DATA_W-1:0] out_data,
   output logic [NUM_CH-1:0]        out_sat,
   output logic [CNT_W-1:0]         overrun_cnt
);

   localparam int ACC_W = DATA_W + AVG_LOG2_MAX;
   localparam logic [3:0] N_MAX = 4'(AVG_LOG2_MAX);

   // Stage 1 signals
   logic [DATA_W-1:0]        d_next [NUM_CH];
   logic [NUM_CH-1:0]        sat_next;
   logic                     st1_valid;
   logic [DATA_W-1:0]        st1_d [NUM_CH];
   logic [NUM_CH-1:0]        st1_sat;

   // Stage 2 signals
   logic [AVG_LOG2_MAX:0]    cnt;
   logic [3:0]               n_lat;
   logic [3:0]               n_cfg;
   logic [3:0]               n_use;
   logic                     first;
   logic                     last;
   logic [ACC_W-1:0]         acc [NUM_CH];
   logic [NUM_CH-1:0]        sat_acc;
   logic                     res_valid;
   logic [NUM_CH*DATA_W-1:0] res_data;

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      logic [DATA_W-1:0] raw;
      logic [DATA_W-1:0] off;
      logic [DATA_W-1:0] s;
      logic [DATA_W:0]   diff;
      logic              ovf;

      assign raw  = in_data[k*DATA_W +: DATA_W];
      assign off  = cfg_dc_off[k*DATA_W +: DATA_W];
      // Offset binary becomes two's complement by flipping the MSB.
      assign s    = raw ^ {cfg_offset_bin, {(DATA_W-1){1'b0}}};
      assign diff = {s[DATA_W-1], s} - {off[DATA_W-1], off};
      // The two top bits of the widened difference disagree only when it left the DATA_W range.
      assign ovf  = diff[DATA_W] ^ diff[DATA_W-1];

      assign d_next[k] = !cfg_ch_en[k] ? '0 :
                         !ovf          ? diff[DATA_W-1:0] :
                         diff[DATA_W]  ? {1'b1, {(DATA_W-1){1'b0}}} :
                                         {1'b0, {(DATA_W-1){1'b1}}};
      assign sat_next[k] = cfg_ch_en[k] & ovf;

      // Block sum divided by 2^N, rounding toward -inf; the mean always fits in DATA_W.
      assign res_data[k*DATA_W +: DATA_W] = DATA_W'($signed(acc[k]) >>> n_lat);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st1_valid <= 1'b0;
         st1_sat   <= '0;
         for (int k = 0; k < NUM_CH; k++) st1_d[k] <= '0;
      end else begin
         st1_valid <= in_valid;
         if (in_valid) begin
            st1_sat <= sat_next;
            for (int k = 0; k < NUM_CH; k++) st1_d[k] <= d_next[k];
         end
      end
   end

   assign n_cfg = (cfg_avg_log2 > N_MAX) ? N_MAX : cfg_avg_log2;
   assign first = (cnt == '0);
   // The block length is frozen at its first sample; later cfg changes wait for the next block.
   assign n_use = first ? n_cfg : n_lat;
   assign last  = (cnt == (((AVG_LOG2_MAX+1)'(1)) << n_use) - 1'b1);

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         n_lat     <= '0;
         sat_acc   <= '0;
         res_valid <= 1'b0;
         for (int k = 0; k < NUM_CH; k++) acc[k] <= '0;
      end else begin
         res_valid <= 1'b0;
         if (st1_valid) begin
            if (first) n_lat <= n_cfg;
            cnt       <= last ? '0 : cnt + 1'b1;
            res_valid <= last;
            sat_acc   <= first ? st1_sat : (sat_acc | st1_sat);
            for (int k = 0; k < NUM_CH; k++) begin
               acc[k] <= first ? {{AVG_LOG2_MAX{st1_d[k][DATA_W-1]}}, st1_d[k]}
                               : acc[k] + {{AVG_LOG2_MAX{st1_d[k][DATA_W-1]}}, st1_d[k]};
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid   <= 1'b0;
         out_data    <= '0;
         out_sat     <= '0;
         overrun_cnt <= '0;
      end else if (res_valid) begin
         // An accept in the same cycle frees the register, so that case is a load.
         if (!out_valid || out_ready) begin
            out_valid <= 1'b1;
            out_data  <= res_data;
            out_sat   <= sat_acc;
         end else if (overrun_cnt != '1) begin
            overrun_cnt <= overrun_cnt + 1'b1;
         end
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_adc_stream_conditioner.sv
// tb/tb_adc_stream_conditioner.sv - scoreboard bench for adc_stream_conditioner
module tb_adc_stream_conditioner;

   localparam int NUM_CH = 4;
   localparam int DATA_W = 12;
   localparam int AVG    = 4;
   localparam int CNT_W  = 4;
   localparam int W      = NUM_CH * DATA_W;

   typedef struct packed {
      logic [W-1:0]      data;
      logic [NUM_CH-1:0] sat;
   } frame_t;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic [W-1:0]      in_data;
   logic              cfg_offset_bin;
   logic [3:0]        cfg_avg_log2;
   logic [NUM_CH-1:0] cfg_ch_en;
   logic [W-1:0]      cfg_dc_off;
   logic              out_valid;
   logic              out_ready;
   logic [W-1:0]      out_data;
   logic [NUM_CH-1:0] out_sat;
   logic [CNT_W-1:0]  overrun_cnt;

   frame_t sb[$];
   int     checks      = 0;
   int     failures    = 0;
   int     frames_seen = 0;
   int     fs;

   adc_stream_conditioner #(
      .NUM_CH(NUM_CH), .DATA_W(DATA_W), .AVG_LOG2_MAX(AVG), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
      .cfg_offset_bin(cfg_offset_bin), .cfg_avg_log2(cfg_avg_log2),
      .cfg_ch_en(cfg_ch_en), .cfg_dc_off(cfg_dc_off),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_sat(out_sat), .overrun_cnt(overrun_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [W-1:0] pk(input logic [11:0] c0, input logic [11:0] c1,
                                       input logic [11:0] c2, input logic [11:0] c3);
      return {c3, c2, c1, c0};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic send(input logic [W-1:0] f);
      in_data  = f;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic expect_frame(input logic [W-1:0] d, input logic [NUM_CH-1:0] s);
      frame_t f;
      f.data = d;
      f.sat  = s;
      sb.push_back(f);
   endtask

   // Monitor: a frame is transferred at the posedge following a negedge with valid & ready.
   always @(negedge clk) begin
      frame_t e;
      if (!rst && out_valid && out_ready) begin
         frames_seen++;
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_frame: got data %0h expected no frame", out_data);
         end else begin
            e = sb.pop_front();
            chk("frame_data", 64'(out_data), 64'(e.data));
            chk("frame_sat", 64'(out_sat), 64'(e.sat));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
      cfg_offset_bin = 1'b1; cfg_avg_log2 = 4'd0; cfg_ch_en = 4'hF; cfg_dc_off = '0;
      idle(3);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_data", 64'(out_data), 64'd0);
      chk("rst_out_sat", 64'(out_sat), 64'd0);
      chk("rst_overrun", 64'(overrun_cnt), 64'd0);
      rst = 1'b0;
      idle(2);
      chk("idle_out_valid", 64'(out_valid), 64'd0);

      // Offset binary conversion and two-cycle latency
      expect_frame(pk(12'h000, 12'h7FF, 12'h800, 12'hFFF), 4'b0000);
      in_data = pk(12'h800, 12'hFFF, 12'h000, 12'h7FF);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      chk("latency_t1_valid", 64'(out_valid), 64'd0);
      tick();
      chk("latency_t2_valid", 64'(out_valid), 64'd1);
      tick();
      chk("accept_drops_valid", 64'(out_valid), 64'd0);
      idle(2);

      // Two's complement with offset subtraction and saturation
      cfg_offset_bin = 1'b0;
      cfg_dc_off = pk(12'h005, 12'hFFF, 12'h003, 12'h000);
      expect_frame(pk(12'h800, 12'h7FF, 12'h00D, 12'h123), 4'b0011);
      send(pk(12'h800, 12'h7FF, 12'h010, 12'h123));
      idle(4);
      cfg_dc_off = '0;

      // Averaging N=2, back to back
      cfg_avg_log2 = 4'd2;
      fs = frames_seen;
      expect_frame(pk(12'd11, 12'hFFE, 12'd0, 12'd101), 4'b0000);
      send(pk(12'd10, 12'hFFF, 12'd0, 12'd100));
      send(pk(12'd11, 12'hFFE, 12'd0, 12'd101));
      send(pk(12'd12, 12'hFFE, 12'd0, 12'd102));
      send(pk(12'd13, 12'hFFE, 12'd0, 12'd103));
      idle(4);
      chk("avg_frame_count", 64'(frames_seen - fs), 64'd1);

      // Same block with in_valid gaps
      fs = frames_seen;
      expect_frame(pk(12'd11, 12'hFFE, 12'd0, 12'd101), 4'b0000);
      send(pk(12'd10, 12'hFFF, 12'd0, 12'd100));
      idle(2);
      send(pk(12'd11, 12'hFFE, 12'd0, 12'd101));
      idle(1);
      send(pk(12'd12, 12'hFFE, 12'd0, 12'd102));
      idle(3);
      chk("gap_mid_valid", 64'(out_valid), 64'd0);
      chk("gap_mid_count", 64'(frames_seen - fs), 64'd0);
      send(pk(12'd13, 12'hFFE, 12'd0, 12'd103));
      idle(4);
      chk("gap_frame_count", 64'(frames_seen - fs), 64'd1);

      // Backpressure: A held, B and C dropped
      cfg_avg_log2 = 4'd0;
      out_ready = 1'b0;
      expect_frame(pk(12'h0A1, 12'h0A2, 12'h0A3, 12'h0A4), 4'b0000);
      send(pk(12'h0A1, 12'h0A2, 12'h0A3, 12'h0A4));
      send(pk(12'h0B1, 12'h0B2, 12'h0B3, 12'h0B4));
      send(pk(12'h0C1, 12'h0C2, 12'h0C3, 12'h0C4));
      idle(4);
      chk("overrun_two", 64'(overrun_cnt), 64'd2);
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_data", 64'(out_data), 64'(pk(12'h0A1, 12'h0A2, 12'h0A3, 12'h0A4)));
      out_ready = 1'b1;
      tick();
      chk("after_accept_valid", 64'(out_valid), 64'd0);

      // Accept and new result in the same cycle is a load
      expect_frame(pk(12'h0D1, 12'h0D2, 12'h0D3, 12'h0D4), 4'b0000);
      expect_frame(pk(12'h0E1, 12'h0E2, 12'h0E3, 12'h0E4), 4'b0000);
      send(pk(12'h0D1, 12'h0D2, 12'h0D3, 12'h0D4));
      send(pk(12'h0E1, 12'h0E2, 12'h0E3, 12'h0E4));
      idle(4);
      chk("overrun_unchanged", 64'(overrun_cnt), 64'd2);

      // N changed mid-block takes effect at the next block
      cfg_avg_log2 = 4'd2;
      fs = frames_seen;
      expect_frame(pk(12'd10, 12'd0, 12'd0, 12'd0), 4'b0000);
      expect_frame(pk(12'd7, 12'd0, 12'd0, 12'd0), 4'b0000);
      send(pk(12'd4, 12'd0, 12'd0, 12'd0));
      send(pk(12'd8, 12'd0, 12'd0, 12'd0));
      cfg_avg_log2 = 4'd0;
      send(pk(12'd12, 12'd0, 12'd0, 12'd0));
      send(pk(12'd16, 12'd0, 12'd0, 12'd0));
      send(pk(12'd7, 12'd0, 12'd0, 12'd0));
      idle(4);
      chk("cfg_change_frames", 64'(frames_seen - fs), 64'd2);

      // Disabled channel outputs zero and no saturation
      cfg_ch_en = 4'b0111;
      cfg_dc_off = pk(12'd0, 12'd0, 12'd0, 12'hFFF);
      expect_frame(pk(12'd1, 12'd2, 12'd3, 12'd0), 4'b0000);
      send(pk(12'd1, 12'd2, 12'd3, 12'h7FF));
      idle(4);
      cfg_ch_en = 4'hF;
      cfg_dc_off = '0;

      // N=9 clamps to 4: 16-sample blocks
      cfg_avg_log2 = 4'd9;
      fs = frames_seen;
      expect_frame(pk(12'd7, 12'hFF8, 12'd0, 12'd0), 4'b0000);
      for (int i = 0; i < 15; i++) send(pk(12'(i), 12'(-i), 12'd0, 12'd0));
      idle(3);
      chk("n9_partial_frames", 64'(frames_seen - fs), 64'd0);
      send(pk(12'd15, 12'(-15), 12'd0, 12'd0));
      idle(4);
      chk("n9_frames", 64'(frames_seen - fs), 64'd1);

      // Reset mid-block discards the partial block
      cfg_avg_log2 = 4'd2;
      fs = frames_seen;
      send(pk(12'd1000, 12'd0, 12'd0, 12'd0));
      send(pk(12'd1000, 12'd0, 12'd0, 12'd0));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_mid_valid", 64'(out_valid), 64'd0);
      chk("rst_mid_data", 64'(out_data), 64'd0);
      chk("rst_mid_sat", 64'(out_sat), 64'd0);
      chk("rst_mid_overrun", 64'(overrun_cnt), 64'd0);
      idle(4);
      chk("rst_mid_no_frame", 64'(frames_seen - fs), 64'd0);
      expect_frame(pk(12'd2, 12'd0, 12'd0, 12'd0), 4'b0000);
      send(pk(12'd1, 12'd0, 12'd0, 12'd0));
      send(pk(12'd2, 12'd0, 12'd0, 12'd0));
      send(pk(12'd3, 12'd0, 12'd0, 12'd0));
      send(pk(12'd4, 12'd0, 12'd0, 12'd0));
      idle(4);
      chk("fresh_avg_frames", 64'(frames_seen - fs), 64'd1);

      // Overrun counter saturation
      cfg_avg_log2 = 4'd0;
      out_ready = 1'b0;
      expect_frame(pk(12'h0F1, 12'h0F2, 12'h0F3, 12'h0F4), 4'b0000);
      send(pk(12'h0F1, 12'h0F2, 12'h0F3, 12'h0F4));
      for (int i = 0; i < 20; i++) send(pk(12'(i + 32), 12'd0, 12'd0, 12'd0));
      idle(4);
      chk("overrun_saturated", 64'(overrun_cnt), 64'hF);
      out_ready = 1'b1;
      idle(4);

      chk("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
